sw_debounce: RTL
================

# sw_debounce

Multi-channel switch/button conditioner that sits directly upstream of `sliding_leds` and the other board-level consumers of `SW`/`BTN`. Each raw input is synchronised into the system clock domain, filtered so that only levels held for `STABLE_CNT` consecutive cycles are accepted, and presented as a clean level plus single-cycle rise and fall strobes. The debounced level vector drives mode inputs such as `sliding_leds.SW` directly.

## Interface
- `WIDTH`, 2: number of independent input channels.
- `STABLE_CNT`, 1000000: consecutive cycles a new level must persist before it is accepted; 10 ms at 100 MHz. Legal range 2 .. 2^`CNT_W`-1.
- `CNT_W`, 24: width of each per-channel stability counter.

- `clk`  in  1  system clock, 100 MHz on the board.
- `rst`  in  1  asynchronous, active-high reset.
- `btn_in`  in  `WIDTH`  raw asynchronous switch/button levels.
- `btn_out`  out  `WIDTH`  debounced level.
- `btn_rise`  out  `WIDTH`  one-cycle strobe when `btn_out[i]` goes 0→1.
- `btn_fall`  out  `WIDTH`  one-cycle strobe when `btn_out[i]` goes 1→0.

## Operation
- Channels are fully independent; the logic below is replicated per bit `i`.
- Synchroniser: two flops, `s1 <= btn_in[i]`, `s2 <= s1`. Only `s2` feeds the filter.
- Filter per channel, one `CNT_W`-bit counter `cnt`, two states implied by `btn_out[i]`:
  - STABLE_LOW (`btn_out`=0) / STABLE_HIGH (`btn_out`=1).
  - If `s2 == btn_out[i]`, then `cnt <= 0`. Any glitch therefore restarts the count.
  - If `s2 != btn_out[i]` and `cnt == STABLE_CNT-1`, then `btn_out[i] <= s2` (state change) and `cnt <= 0`.
  - If `s2 != btn_out[i]` and `cnt < STABLE_CNT-1`, then `cnt <= cnt+1`.
- Strobes are registered:
  - `btn_rise[i]` = 1 in exactly the cycle in which `btn_out[i]` first reads 1.
  - `btn_fall[i]` = 1 in exactly the cycle in which `btn_out[i]` first reads 0.
  - Both strobes are 0 otherwise and never 1 together.
- Counter never wraps: the maximum value reached is `STABLE_CNT-1`.
- Reset (async assert, synchronous-safe release):
  - `s1`, `s2`, `cnt` and `btn_out` all clear to 0, as do `btn_rise` and `btn_fall`.
  - Reset asserted mid-count discards the count immediately.
  - An input held high through reset release is re-qualified from zero and produces a normal `btn_rise`.
  - No strobe is ever generated by reset itself.

## Timing
- Edge numbering: edge 1 is the first rising `clk` edge that samples the new `btn_in[i]` level.
- Latency: after edge 1 with the new level held, `btn_out[i]` changes after edge `STABLE_CNT+2`. At the default this is 1000002 cycles.
- The matching strobe is high for the one cycle following that same edge.
- Rejection:
  - A level held in `s2` for fewer than `STABLE_CNT` consecutive cycles has no effect on outputs.
  - A pulse of exactly `STABLE_CNT` cycles in `s2` is accepted.
- Back-to-back transitions:
  - Minimum spacing between two `btn_out[i]` changes is `STABLE_CNT` cycles.
  - A strobe therefore never lasts more than one cycle.
- Simultaneous events: channels changing in the same cycle update and strobe in the same cycle, with no arbitration.
- Throughput: no handshake; the consumer samples `btn_out` or strobes on any edge.

## Test plan
Simulate with `STABLE_CNT`=4, `WIDTH`=2 and a 10 ns clock.
- Clean press: `btn_in`=01, held 20 cycles from edge 1.
  - `btn_out`=01 after edge 6, `btn_rise`=01 for one cycle, `btn_fall`=00 throughout.
- Bounce rejection: `btn_in[0]` toggles high 3 cycles / low 2 cycles, repeated 5 times, then stays low.
  - `btn_out` stays 00 and no strobe fires.
- Bounce then settle: same bounce, then high for 10 cycles.
  - `btn_out[0]` rises exactly 6 edges after the final 0→1 sample, with a single `btn_rise[0]`.
- Release and independence: `btn_out`=01; set `btn_in`=10 in one cycle.
  - After 6 edges `btn_out`=10, with `btn_fall`=01 and `btn_rise`=10 in the same single cycle.
- Reset mid-count: `btn_in`=11; assert `rst` for 1 cycle after edge 4.
  - All outputs 0 immediately and asynchronously, not waiting for a clock edge.
  - After release, `btn_out`=11 only 6 edges after the first post-reset sampling edge, with `btn_rise`=11 once.
- Boundary pulse: `btn_in[1]` high for exactly 4 cycles (so 4 cycles in `s2`).
  - `btn_out[1]` goes 1. The subsequent low level is accepted 4 cycles after it reaches `s2`, with `btn_fall[1]` once.

Source files
------------

// File: rtl/sw_debounce.sv
// Multi-channel switch/button conditioner: two-flop synchroniser, per-channel
// stability counter, clean level output and registered one-cycle edge strobes.
module sw_debounce #(
    parameter int WIDTH      = 2,
    parameter int STABLE_CNT = 1000000,
    parameter int CNT_W      = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] btn_in,
    output logic [WIDTH-1:0] btn_out,
    output logic [WIDTH-1:0] btn_rise,
    output logic [WIDTH-1:0] btn_fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    logic [WIDTH-1:0] s1_q, s2_q;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // A sample that agrees with the accepted level restarts the count, so any
    // glitch forces a full STABLE_CNT run of the new level before acceptance.
    always_comb begin
        out_d  = out_q;
        rise_d = '0;
        fall_d = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != out_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    out_d[i]  = s2_q[i];
                    rise_d[i] = s2_q[i];
                    fall_d[i] = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= '0;
            s2_q   <= '0;
            out_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q   <= btn_in;
            s2_q   <= s1_q;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign btn_out  = out_q;
    assign btn_rise = rise_q;
    assign btn_fall = fall_q;

endmodule
